// File: rtl/xgmii_tx_arb.sv
// Two-source packet arbiter feeding an XGMII-TX FIFO, with IFG insertion,
// per-source packet counters and a protocol-error counter.
module xgmii_tx_arb #(
    parameter logic [2:0] Gap = 3'd7
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [71:0] s0_din,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [71:0] s1_din,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic        full,
    output logic [71:0] din,
    output logic        wr_en,
    output logic [31:0] pkt_cnt0,
    output logic [31:0] pkt_cnt1,
    output logic [15:0] err_cnt
);

    localparam int unsigned WordW  = 72;
    localparam int unsigned BitSop = 64;
    localparam int unsigned BitEop = 65;
    localparam logic [WordW-1:0] IfgWord = {8'h10, 64'h0};

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DATA  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               lst_q, lst_d;
    logic               first_q, first_d;
    logic [2:0]         gap_q, gap_d;
    logic [WordW-1:0]   din_q, din_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        pkt_cnt0_q, pkt_cnt0_d;
    logic [31:0]        pkt_cnt1_q, pkt_cnt1_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic               drop0, drop1;
    logic               cand0, cand1;
    logic               xfer;
    logic [WordW-1:0]   sel_word;

    // Handshake: granted source in DATA, or a malformed head word dropped in IDLE
    always_comb begin
        drop0    = (state_q == ST_IDLE) && !full && s0_valid && !s0_din[BitSop];
        drop1    = (state_q == ST_IDLE) && !full && !drop0 && s1_valid && !s1_din[BitSop];
        s0_ready = ((state_q == ST_DATA) && !gnt_q && !full) || drop0;
        s1_ready = ((state_q == ST_DATA) &&  gnt_q && !full) || drop1;
        cand0    = s0_valid && s0_din[BitSop];
        cand1    = s1_valid && s1_din[BitSop];
        xfer     = gnt_q ? (s1_valid && s1_ready) : (s0_valid && s0_ready);
        sel_word = gnt_q ? s1_din : s0_din;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        lst_d      = lst_q;
        first_d    = first_q;
        gap_d      = gap_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_RESET: begin
                if (!full) begin
                    din_d   = '0;
                    wr_en_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (drop0 || drop1) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
                if (cand0 || cand1) begin
                    if (cand0 && cand1) begin
                        gnt_d = ~lst_q;
                    end else begin
                        gnt_d = cand1;
                    end
                    first_d = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    din_d   = sel_word;
                    wr_en_d = 1'b1;
                    first_d = 1'b0;
                    if (sel_word[BitSop] && !first_q) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (sel_word[BitEop]) begin
                        lst_d = gnt_q;
                        if (gnt_q) begin
                            pkt_cnt1_d = pkt_cnt1_q + 32'd1;
                        end else begin
                            pkt_cnt0_d = pkt_cnt0_q + 32'd1;
                        end
                        if (Gap == 3'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            gap_d   = Gap;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (!full) begin
                    din_d   = IfgWord;
                    wr_en_d = 1'b1;
                    gap_d   = gap_q - 3'd1;
                    if (gap_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_RESET;
            gnt_q      <= 1'b0;
            lst_q      <= 1'b1;
            first_q    <= 1'b0;
            gap_q      <= 3'd0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
            pkt_cnt0_q <= 32'd0;
            pkt_cnt1_q <= 32'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            lst_q      <= lst_d;
            first_q    <= first_d;
            gap_q      <= gap_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign din      = din_q;
    assign wr_en    = wr_en_q;
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_arb.sv
// Scoreboard bench for xgmii_tx_arb: stimulus queues expected FIFO writes,
// a negedge monitor pops and compares every write.
module tb_xgmii_tx_arb;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [71:0] s0_din, s1_din;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic        full;
    logic [71:0] din;
    logic        wr_en;
    logic [31:0] pkt_cnt0, pkt_cnt1;
    logic [15:0] err_cnt;

    localparam logic [71:0] IFG = {8'h10, 64'h0};

    xgmii_tx_arb #(.Gap(3'd7)) dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .s0_din   (s0_din),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s1_din   (s1_din),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .full     (full),
        .din      (din),
        .wr_en    (wr_en),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    logic [71:0] exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] mk(input logic [63:0] d, input logic sop, input logic eop);
        return {3'b000, 1'b0, 1'b1, 1'b1, eop, sop, d};
    endfunction

    // Monitor: in-order scoreboard, one-cycle latency, full blocking
    logic        xfer_prev = 1'b0;
    logic [71:0] xfer_word = '0;
    logic        full_prev = 1'b0;
    logic        in_pkt    = 1'b0;
    logic [71:0] exp_w;
    logic        hs;
    logic [71:0] hs_word;

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            xfer_prev = 1'b0;
            full_prev = 1'b0;
            in_pkt    = 1'b0;
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", din, 72'hx);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("scoreboard_din", din, exp_w);
                end
            end
            if (xfer_prev) begin
                chk("latency_wr_en", 72'(wr_en), 72'd1);
                chk("latency_din", din, xfer_word);
            end
            if (full_prev) chk("full_blocks_write", 72'(wr_en), 72'd0);
            if (full) chk("full_blocks_ready", 72'({s0_ready, s1_ready}), 72'd0);
            hs      = 1'b0;
            hs_word = '0;
            if (s0_valid && s0_ready) begin hs = 1'b1; hs_word = s0_din; end
            else if (s1_valid && s1_ready) begin hs = 1'b1; hs_word = s1_din; end
            xfer_prev = 1'b0;
            if (hs && (in_pkt || hs_word[64])) begin
                xfer_prev = 1'b1;
                xfer_word = hs_word;
                in_pkt    = !hs_word[65];
            end
            full_prev = full;
        end
    end

    task automatic send_word(input int src, input logic [71:0] w);
        int  k;
        logic rdy;
        if (src == 0) begin s0_din = w; s0_valid = 1'b1; end
        else          begin s1_din = w; s1_valid = 1'b1; end
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 300) begin
            @(negedge clk);
            rdy = (src == 0) ? s0_ready : s1_ready;
            k++;
        end
        if (!rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: src %0d never ready, expected handshake", src);
        end else begin
            @(posedge clk);
            #1;
        end
        if (src == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
    endtask

    task automatic send_pkt(input int src, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) send_word(src, mk(base + 64'(i), i == 0, i == n - 1));
    endtask

    task automatic push_pkt(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(base + 64'(i), i == 0, i == n - 1));
        for (int i = 0; i < 7; i++) exp_q.push_back(IFG);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_din", din, 72'h0);
        chk("rst_wr_en", 72'(wr_en), 72'd0);
        chk("rst_ready", 72'({s0_ready, s1_ready}), 72'd0);
        chk("rst_counters", {8'h0, pkt_cnt0, pkt_cnt1} | 72'(err_cnt), 72'd0);
    endtask

    task automatic reset_pulse();
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        exp_q.push_back(72'h0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        full      = 1'b0;
        s0_valid  = 1'b0;
        s1_valid  = 1'b0;
        s0_din    = '0;
        s1_din    = '0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        exp_q.push_back(72'h0);
        repeat (5) @(posedge clk);
        #1;
        drain();

        // 3-word packet from s0 followed by 7 IFG words
        push_pkt(64'hA000, 3);
        send_pkt(0, 64'hA000, 3);
        drain();
        chk("pkt_cnt0_single", 72'(pkt_cnt0), 72'd1);

        // Both sources contend right after reset: s0 first, then s1
        reset_pulse();
        drain();
        push_pkt(64'hB000, 3);
        push_pkt(64'hC000, 2);
        fork
            send_pkt(0, 64'hB000, 3);
            send_pkt(1, 64'hC000, 2);
        join
        drain();
        chk("pkt_cnt0_arb", 72'(pkt_cnt0), 72'd1);
        chk("pkt_cnt1_arb", 72'(pkt_cnt1), 72'd1);

        // Four-cycle full stall mid-packet
        push_pkt(64'hD000, 4);
        fork
            send_pkt(0, 64'hD000, 4);
            begin
                repeat (3) @(posedge clk);
                #1 full = 1'b1;
                repeat (4) @(posedge clk);
                #1 full = 1'b0;
            end
        join
        drain();
        chk("pkt_cnt0_stall", 72'(pkt_cnt0), 72'd2);

        // Head word without start bit is dropped, then a proper packet
        send_word(1, mk(64'hBAD, 1'b0, 1'b0));
        chk("err_cnt_drop", 72'(err_cnt), 72'd1);
        chk("drop_no_write", 72'(wr_en), 72'd0);
        push_pkt(64'hE000, 3);
        send_pkt(1, 64'hE000, 3);
        drain();
        chk("pkt_cnt1_after_drop", 72'(pkt_cnt1), 72'd2);

        // Stray start inside a packet is forwarded and counted; single-word packet
        exp_q.push_back(mk(64'hF000, 1'b1, 1'b0));
        exp_q.push_back(mk(64'hF001, 1'b1, 1'b0));
        exp_q.push_back(mk(64'hF002, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) exp_q.push_back(IFG);
        push_pkt(64'h1234, 1);
        send_word(0, mk(64'hF000, 1'b1, 1'b0));
        send_word(0, mk(64'hF001, 1'b1, 1'b0));
        send_word(0, mk(64'hF002, 1'b0, 1'b1));
        send_pkt(1, 64'h1234, 1);
        drain();
        chk("err_cnt_stray_start", 72'(err_cnt), 72'd2);
        chk("pkt_cnt0_stray", 72'(pkt_cnt0), 72'd3);
        chk("pkt_cnt1_single_word", 72'(pkt_cnt1), 72'd3);

        // Reset while word 2 of a packet is pending
        exp_q.push_back(mk(64'h5000, 1'b1, 1'b0));
        exp_q.push_back(mk(64'h5001, 1'b0, 1'b0));
        send_word(0, mk(64'h5000, 1'b1, 1'b0));
        send_word(0, mk(64'h5001, 1'b0, 1'b0));
        s0_din   = mk(64'h5002, 1'b0, 1'b1);
        s0_valid = 1'b1;
        @(negedge clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals();
        s0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        exp_q.push_back(72'h0);
        push_pkt(64'h6000, 3);
        send_pkt(0, 64'h6000, 3);
        drain();
        chk("pkt_cnt0_after_reset", 72'(pkt_cnt0), 72'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xgmii_tx_arb.md
XGMII_TX_ARB -- requirements
Module: xgmii_tx_arb

Interface
REQ-001 Parameter Gap, default 3'd7, IFG words emitted after each packet's last word.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 s0_din  in  72  source 0 word (b63-0 data, b64 start, b65 last, b66 lo-enable, b67 hi-enable, b68 IFG, b71-69 zero).
REQ-005 s0_valid  in  1  source 0 word present.
REQ-006 s0_ready  out  1  source 0 word accepted this cycle when s0_valid also high.
REQ-007 s1_din / s1_valid / s1_ready  in 72 / in 1 / out 1  source 1, same meaning.
REQ-008 full  in  1  XGMII-TX FIFO programmable-full; FIFO guarantees >=1 free entry while high.
REQ-009 din  out  72  registered word to XGMII-TX FIFO.
REQ-010 wr_en  out  1  registered FIFO write strobe.
REQ-011 pkt_cnt0, pkt_cnt1  out  32  packets forwarded per source (incremented on accepted last word).
REQ-012 err_cnt  out  16  protocol errors (REQ-021, REQ-022).

Function
REQ-013 States SHALL be RESET, IDLE, DATA, GAP; grant register gnt (0/1) and last-served register lst.
REQ-014 Handshake: word transfers on sN_valid & sN_ready; sN_ready SHALL be combinational, high only when (gnt==N & state==DATA & !full) or per REQ-021.
REQ-015 Latency: accepted word SHALL appear on din with wr_en=1 exactly one cycle after transfer, bits unchanged.
REQ-016 wr_en SHALL be 0 in any cycle not caused by a transfer, RESET dummy or GAP word; din holds last value when wr_en=0.
REQ-017 RESET: when !full, write one word 72'h0 (wr_en=1) and go IDLE; stay otherwise.
REQ-018 IDLE arbitration: candidates are sources with valid & start bit; one candidate -> grant it; both -> grant ~lst; go DATA next cycle (one idle arbitration cycle, no transfer in IDLE for the winner).
REQ-019 DATA: forward granted source's words; on transfer of word with last=1: lst<=gnt, pkt_cntN+1, go GAP with gap counter=Gap, or IDLE directly if Gap==0.
REQ-020 GAP: each cycle with !full write {8'h10,64'h0} and decrement; after Gap words go IDLE; full high stalls counter with wr_en=0.
REQ-021 IDLE head word with valid & start=0: SHALL be dropped (sN_ready=1, no write), err_cnt+1; source 0 checked before source 1, one drop per cycle.
REQ-022 DATA word with start=1 after packet's first word: forwarded unchanged, err_cnt+1, packet continues.
REQ-023 Word with start=1 and last=1: single-word packet, DATA -> GAP/IDLE after that one transfer.
REQ-024 Non-granted source SHALL see ready=0 throughout DATA and GAP; no interleaving of packets.
REQ-025 full sampled high SHALL block every transfer and GAP write that cycle; no word lost or duplicated.
REQ-026 Counters SHALL wrap modulo 2^width; err_cnt wraps 16'hFFFF->0.

Reset
REQ-027 On sys_rst_n low, immediately: state=RESET, din=72'h0, wr_en=0, s0_ready=s1_ready=0, gnt=0, lst=1, gap counter=0, all counters 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; no further words written until RESET dummy after release.

Verification
REQ-029 Release reset, full=0 -> one write 72'h0, then wr_en=0 while no valid.
REQ-030 s0 3-word packet (start on w0, last on w2), Gap=7 -> 3 writes 1 cycle after each transfer, then 7 writes of 72'h10_0000000000000000, pkt_cnt0=1.
REQ-031 s0 and s1 both present start words in IDLE after reset (lst=1) -> s0 granted first, s1 packet follows only after s0's 7 IFG words; pkt_cnt0=pkt_cnt1=1.
REQ-032 full held high 4 cycles mid-packet -> sN_ready=0, wr_en=0 those 4 cycles; output sequence identical to no-stall run.
REQ-033 s1 presents start=0 word in IDLE -> dropped, err_cnt=1, no write; following proper packet forwarded normally.
REQ-034 sys_rst_n low during DATA word 2 -> all outputs reset values at once; after release RESET dummy written, next packet starts from its start word.
